// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared reset address, fetch FSM states and instruction field positions
package fetch_unit_pkg;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  typedef enum logic {RUN = 1'b0, DROP = 1'b1} fetch_state_e;
  localparam int OPCODE_MSB = 6;
  localparam int OPCODE_LSB = 0;
  localparam int FUNCT3_MSB = 14;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT7_MSB = 31;
  localparam int FUNCT7_LSB = 25;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry FIFO of fetched {instr, pc} pairs with flush and occupancy count
module fetch_queue #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic         head_valid,
  output logic [W-1:0] head_data,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic rd, wr, do_push, do_pop;
  assign do_pop = pop && count != 2'd0;
  assign do_push = push && (count != 2'd2 || do_pop);
  assign head_valid = count != 2'd0;
  assign head_data = mem[rd];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd <= 1'b0;
      wr <= 1'b0;
      count <= 2'd0;
    end else if (flush) begin
      rd <= 1'b0;
      wr <= 1'b0;
      count <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr] <= push_data;
        wr <= ~wr;
      end
      if (do_pop) rd <= ~rd;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with a 2-entry queue and redirect/drop handling
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7
);
  fetch_state_e state;
  logic [31:0] pc, rsp_pc;
  logic outstanding, rsp, pop, push, accept, owed, head_valid;
  logic [1:0] count;
  logic [2:0] used;
  logic [63:0] head;
  assign rsp = imem_rvalid && outstanding;
  assign pop = head_valid && !stall;
  // a returning word moves from outstanding to occupancy, so only a pop frees a slot
  assign used = 3'(count) + 3'(outstanding) - 3'(pop);
  assign imem_req = !rst && state == RUN && used < 3'd2 && !(outstanding && !rsp);
  assign accept = imem_req && imem_ready;
  assign owed = accept || (outstanding && !rsp);
  assign push = rsp && state == RUN && !redirect;
  assign imem_addr = pc;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
      rsp_pc <= '0;
      state <= RUN;
      outstanding <= 1'b0;
    end else begin
      outstanding <= owed;
      if (accept) rsp_pc <= pc;
      state <= redirect ? (owed ? DROP : RUN) : (state == DROP && rsp) ? RUN : state;
      pc <= redirect ? {redirect_pc[31:2], 2'b00} : accept ? pc + 32'd4 : pc;
    end
  end
  fetch_queue #(.W(64)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (push),
    .pop       (pop),
    .push_data ({imem_rdata, rsp_pc}),
    .head_valid(head_valid),
    .head_data (head),
    .count     (count)
  );
  assign instr_valid = head_valid;
  assign instr = head_valid ? head[63:32] : '0;
  assign instr_pc = head_valid ? head[31:0] : '0;
  assign opcode = instr[OPCODE_MSB:OPCODE_LSB];
  assign funct3 = instr[FUNCT3_MSB:FUNCT3_LSB];
  assign funct7 = instr[FUNCT7_MSB:FUNCT7_LSB];
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a fetch-stream reference model
module tb_fetch_unit;
  logic clk = 1'b0, rst = 1'b1;
  logic imem_req, imem_ready, imem_rvalid, stall, redirect, instr_valid;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic w_req, w_valid;
  logic [31:0] w_addr, w_instr, w_pc;
  logic [6:0] w_op, w_f7;
  logic [2:0] w_f3;
  int checks = 0, errors = 0, npop = 0, lat = 0, next_lat = 0;
  logic pend = 1'b0, stale = 1'b0, redir_prev = 1'b0;
  logic const_mode = 1'b1, rand_mode = 1'b0, spur_en = 1'b0;
  logic drv_ready = 1'b0, drv_stall = 1'b0, drv_redirect = 1'b0;
  logic [31:0] drv_rpc = '0, pend_addr = '0, exp_fetch = '0, exp_next = '0;
  logic s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_instr;
  logic [6:0] s_op;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .opcode(opcode), .funct3(funct3), .funct7(funct7)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr), .imem_ready(1'b1),
    .imem_rvalid(1'b0), .imem_rdata(32'h0), .stall(1'b0), .redirect(1'b0),
    .redirect_pc(32'h0), .instr_valid(w_valid), .instr(w_instr), .instr_pc(w_pc),
    .opcode(w_op), .funct3(w_f3), .funct7(w_f7)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic [31:0] a);
    return const_mode ? 32'h0000_0013 : (a * 32'h9E37_79B1) ^ 32'h0000_5A13;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    {imem_ready, imem_rvalid, stall, redirect} = '0;
    redirect_pc = '0;
    imem_rdata = '0;
    {drv_ready, drv_stall, drv_redirect} = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", 32'(imem_req), 0);
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_addr", imem_addr, 0);
    check("rst_data", instr | instr_pc | 32'({opcode, funct3, funct7}), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    {pend, stale, redir_prev} = '0;
    exp_fetch = '0;
    exp_next = '0;
    npop = 0;
  endtask

  task automatic cyc();
    logic rv, acc;
    logic [31:0] ew;
    @(negedge clk);
    if (rand_mode) begin
      drv_ready = $urandom_range(0, 9) < 7;
      drv_stall = $urandom_range(0, 9) < 3;
      drv_redirect = $urandom_range(0, 39) == 0;
      drv_rpc = $urandom;
      next_lat = $urandom_range(0, 3);
    end
    rv = pend && lat == 0;
    imem_rvalid = rv;
    imem_rdata = word(pend_addr);
    if (!pend && spur_en && $urandom_range(0, 15) == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata = $urandom;
    end
    imem_ready = drv_ready;
    stall = drv_stall;
    redirect = drv_redirect;
    redirect_pc = drv_rpc;
    #1;
    {s_req, s_valid, s_addr, s_pc, s_instr, s_op} = {imem_req, instr_valid, imem_addr, instr_pc, instr, opcode};
    check("addr", imem_addr, exp_fetch);
    check("one_out", 32'(imem_req && pend && !rv), 0);
    check("drop_req", 32'(imem_req && stale), 0);
    if (redir_prev) check("flush", 32'(instr_valid), 0);
    ew = instr_valid ? word(exp_next) : 32'h0;
    check("pc", instr_pc, instr_valid ? exp_next : 32'h0);
    check("instr", instr, ew);
    check("fields", {15'h0, opcode, funct3, funct7}, {15'h0, ew[6:0], ew[14:12], ew[31:25]});
    acc = imem_req && imem_ready;
    if (rv) begin
      pend = 1'b0;
      stale = 1'b0;
    end else if (pend) lat--;
    if (redirect && (acc || pend)) stale = 1'b1;
    if (acc) begin
      pend = 1'b1;
      lat = next_lat;
      pend_addr = imem_addr;
    end
    if (instr_valid && !stall && !redirect) begin
      exp_next += 4;
      npop++;
    end
    redir_prev = redirect;
    if (redirect) begin
      exp_fetch = {drv_rpc[31:2], 2'b00};
      exp_next = exp_fetch;
    end else if (acc) exp_fetch += 4;
  endtask

  initial begin
    // zero-wait stream of NOPs, plus the wrapping reset address instance
    do_reset();
    drv_ready = 1'b1;
    cyc();
    check("t1_a0", s_addr, 32'h0);
    check("t1_req0", 32'(s_req), 1);
    check("t1_v0", 32'(s_valid), 0);
    check("wrap_a0", w_addr, 32'hFFFF_FFFC);
    cyc();
    check("t1_a1", s_addr, 32'h4);
    check("t1_v1", 32'(s_valid), 0);
    check("wrap_a1", w_addr, 32'h0);
    cyc();
    check("t1_a2", s_addr, 32'h8);
    check("t1_v2", 32'(s_valid), 1);
    check("t1_op", 32'(s_op), 32'h13);
    check("wrap_idle", 32'(w_valid) | w_instr | w_pc | 32'({w_op, w_f3, w_f7, w_req}), 0);
    // stall with a full queue, then drain
    do_reset();
    const_mode = 1'b0;
    drv_ready = 1'b1;
    drv_stall = 1'b1;
    repeat (3) cyc();
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("t2_req", 32'(s_req), 0);
      check("t2_valid", 32'(s_valid), 1);
      check("t2_pc", s_pc, 32'h0);
      check("t2_instr", s_instr, word(32'h0));
    end
    drv_stall = 1'b0;
    repeat (10) cyc();
    check("t2_pops", exp_next, 32'd40);
    // redirect while a request is outstanding
    do_reset();
    drv_ready = 1'b1;
    cyc();
    drv_redirect = 1'b1;
    drv_rpc = 32'h0000_0102;
    cyc();
    drv_redirect = 1'b0;
    cyc();
    check("t3_addr", s_addr, 32'h100);
    check("t3_req_drop", 32'(s_req), 0);
    check("t3_v0", 32'(s_valid), 0);
    cyc();
    check("t3_req", 32'(s_req), 1);
    check("t3_v1", 32'(s_valid), 0);
    repeat (2) cyc();
    check("t3_v2", 32'(s_valid), 1);
    check("t3_pc", s_pc, 32'h100);
    // memory not ready for three cycles
    do_reset();
    drv_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("t4_hold", s_addr, 32'h0);
      check("t4_req", 32'(s_req), 1);
    end
    drv_ready = 1'b1;
    cyc();
    drv_ready = 1'b0;
    cyc();
    check("t4_next", s_addr, 32'h4);
    // asynchronous reset while waiting on a slow response
    do_reset();
    drv_ready = 1'b1;
    drv_stall = 1'b1;
    next_lat = 0;
    cyc();
    next_lat = 5;
    repeat (2) cyc();
    check("t6_pre_valid", 32'(s_valid), 1);
    #2 rst = 1'b1;
    #1;
    check("t6_req", 32'(imem_req), 0);
    check("t6_valid", 32'(instr_valid), 0);
    check("t6_data", instr | instr_pc | 32'({opcode, funct3, funct7}), 0);
    do_reset();
    pend = 1'b1;
    lat = 0;
    pend_addr = 32'h4;
    drv_ready = 1'b1;
    next_lat = 0;
    repeat (3) cyc();
    check("t6_post_valid", 32'(s_valid), 1);
    check("t6_post_pc", s_pc, 32'h0);
    check("t6_post_instr", s_instr, word(32'h0));
    // randomized traffic against the reference model
    do_reset();
    rand_mode = 1'b1;
    spur_en = 1'b1;
    repeat (3000) cyc();
    rand_mode = 1'b0;
    check("rand_progress", 32'(npop > 300), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, address of first fetch after reset (bits [1:0] SHALL be 00).
REQ-002 SHALL have ports, one per line, name direction width meaning:
  clk  in  1  single clock, all state on rising edge
  rst  in  1  reset, asynchronous, active-high
  imem_req  out  1  fetch request valid
  imem_addr  out  32  fetch byte address
  imem_ready  in  1  memory accepts request this cycle
  imem_rvalid  in  1  instruction word returned this cycle
  imem_rdata  in  32  returned instruction word
  stall  in  1  downstream (decode/control) cannot accept head instruction
  redirect  in  1  taken branch/jump from execute; flush and refetch
  redirect_pc  in  32  new fetch address
  instr_valid  out  1  queue head valid
  instr  out  32  queue head instruction
  instr_pc  out  32  PC of queue head
  opcode  out  7  instr[6:0], feeds control unit
  funct3  out  3  instr[14:12]
  funct7  out  7  instr[31:25]

Function
REQ-003 SHALL hold fetch PC register pc; imem_addr = pc at all times.
REQ-004 Request accepted when imem_req && imem_ready; on acceptance pc += 4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-005 imem_addr SHALL stay stable while imem_req && !imem_ready.
REQ-006 At most one outstanding request (accepted, rvalid not yet seen).
REQ-007 Instruction queue: 2 entries, each {instr, pc}; rvalid writes tail, registered; head visible cycle after rvalid.
REQ-008 Pop when instr_valid && !stall; push and pop in same cycle SHALL be allowed, occupancy unchanged.
REQ-009 imem_req SHALL assert only when occupancy + outstanding < 2, counting this cycle's pop and rvalid as completed; never when in DROP.
REQ-010 Zero-wait memory (ready=1, rvalid next cycle), stall=0: sustained one instruction per cycle.
REQ-011 opcode/funct3/funct7 SHALL be combinational slices of instr; instr/instr_pc/fields SHALL be 0 when instr_valid=0.
REQ-012 FSM states: RUN (normal), DROP (one outstanding response to discard); RUN->DROP on redirect with request outstanding or accepted that cycle; DROP->RUN on imem_rvalid.
REQ-013 On redirect: pc <= {redirect_pc[31:2],2'b00}; queue flushed; instr_valid=0 next cycle; imem_rdata of any rvalid same cycle discarded.
REQ-014 Redirect SHALL take priority over stall, pop, push and request acceptance bookkeeping.
REQ-015 Redirect while in DROP SHALL update pc and remain in DROP (still one response owed).
REQ-016 imem_rvalid with no outstanding request SHALL be ignored.
REQ-017 stall with instr_valid=0 SHALL have no effect.

Reset
REQ-018 While rst=1: pc=RESET_PC, queue empty, outstanding=0, state RUN, imem_req=0, instr_valid=0, all data outputs 0.
REQ-019 First cycle after rst deasserts: imem_req=1, imem_addr=RESET_PC.
REQ-020 rst mid-transaction SHALL discard the outstanding request; no DROP state after reset.

Structure
REQ-021 Shared package SHALL hold RESET_PC default, FSM state enum, instruction field bit positions.
REQ-022 Queue SHALL be sub-module fetch_queue (2-entry FIFO, push/pop/flush, count out).
REQ-023 Total RTL 120-400 lines; no latches; no combinational path imem_rvalid -> imem_req except via REQ-009 credit term.

Verification
REQ-024 Reset release, ready=1, 1-cycle memory returning 32'h00000013 -> imem_addr 0,4,8 consecutive cycles; instr_valid first high 2 cycles after release, opcode=7'h13.
REQ-025 stall held 5 cycles with queue full -> imem_req=0, occupancy 2, instr/instr_pc unchanged; release -> in-order delivery, no loss or duplicate.
REQ-026 redirect to 32'h0000_0102 while request outstanding -> next fetch addr 32'h0000_0100, stale rvalid word never reaches instr, instr_valid=0 for ≥1 cycle.
REQ-027 imem_ready low 3 cycles -> imem_addr stable, pc advances by exactly 4 after acceptance.
REQ-028 RESET_PC=32'hFFFF_FFFC -> second fetch address 32'h0000_0000.
REQ-029 rst asserted asynchronously mid-WAIT -> outputs zero immediately; late rvalid after release ignored.
